// File: rtl/fpm_issue_ctrl.sv
// fpm_issue_ctrl: issue controller and WAW scoreboard that shares a single
// combinational FP16 multiplier among NREQ requesters.
//
// A round-robin arbiter picks one eligible request per cycle and drives the
// multiplier operands. The product is carried with its requester id and
// destination register through a LAT-stage writeback pipeline. A per-register
// busy table blocks any request whose destination still has a result in flight.
//
// Optional feature (macro FPM_PERF_CNT_EN): adds saturating 16-bit issue and
// stall counters on ports issue_cnt / stall_cnt.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid[NREQ]       per-requester request valid
//   req_a/req_b           packed FP16 operands, requester i at [16i+15:16i]
//   req_dst               packed destination register per requester
//   req_ready[NREQ]       one-hot grant
//   mul_a/mul_b           operands to the shared multiplier
//   mul_out               multiplier product (combinational from mul_a/mul_b)
//   wb_valid/id/dst/data  writeback of one result per cycle
//   busy[NREG]            scoreboard busy bits
//   issue_cnt/stall_cnt   performance counters (FPM_PERF_CNT_EN only)
module fpm_issue_ctrl #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned LAT  = 3,
  localparam int unsigned IDW = $clog2(NREQ),
  localparam int unsigned DW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  input  logic [DW*NREQ-1:0]   req_dst,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_out,
  output logic                 wb_valid,
  output logic [IDW-1:0]       wb_id,
  output logic [DW-1:0]        wb_dst,
  output logic [15:0]          wb_data,
  output logic [NREG-1:0]      busy
`ifdef FPM_PERF_CNT_EN
  ,
  output logic [15:0]          issue_cnt,
  output logic [15:0]          stall_cnt
`endif
);

  logic [NREG-1:0] r_busy;
  logic [IDW-1:0]  r_ptr;

  logic           r_vld  [LAT];
  logic [IDW-1:0] r_id   [LAT];
  logic [DW-1:0]  r_dst  [LAT];
  logic [15:0]    r_data [LAT];

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic            w_any;
  logic [IDW-1:0]  w_gid;
  logic [IDW-1:0]  w_idx;
  logic [DW-1:0]   w_gdst;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  // Eligibility uses the registered busy table, so a destination cleared by
  // this cycle's writeback only becomes available next cycle. Gating with rst
  // keeps req_ready low while reset is asserted.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_elig[i] = ~rst & req_valid[i] & ~r_busy[req_dst[i*DW +: DW]];
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((32'(r_ptr) + k) % NREQ);
      if (!w_any && w_elig[w_idx]) begin
        w_any          = 1'b1;
        w_gid          = w_idx;
        w_grant[w_idx] = 1'b1;
      end
    end
  end

  assign w_gdst    = req_dst[32'(w_gid)*DW +: DW];
  assign req_ready = w_grant;
  assign mul_a     = w_any ? req_a[32'(w_gid)*16 +: 16] : '0;
  assign mul_b     = w_any ? req_b[32'(w_gid)*16 +: 16] : '0;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_any)    w_set[w_gdst] = 1'b1;
    if (wb_valid) w_clr[wb_dst] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_ptr  <= IDW'(NREQ - 1);
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (w_any) r_ptr <= w_gid;
    end
  end

  // Writeback pipeline: free-running shift, no backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_vld[i]  <= 1'b0;
        r_id[i]   <= '0;
        r_dst[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_vld[0]  <= w_any;
      r_id[0]   <= w_gid;
      r_dst[0]  <= w_gdst;
      r_data[0] <= mul_out;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_id[i]   <= r_id[i-1];
        r_dst[i]  <= r_dst[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

  assign wb_valid = r_vld[LAT-1];
  assign wb_id    = r_id[LAT-1];
  assign wb_dst   = r_dst[LAT-1];
  assign wb_data  = r_data[LAT-1];
  assign busy     = r_busy;

`ifdef FPM_PERF_CNT_EN
  logic [15:0] r_issue_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_any && r_issue_cnt != '1) r_issue_cnt <= r_issue_cnt + 16'd1;
      if ((|req_valid) && !w_any && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign issue_cnt = r_issue_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fpm_issue_ctrl.sv
module tb_fpm_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [11:0] req_dst;
  logic [3:0]  req_ready;
  logic [15:0] mul_a, mul_b, mul_out;
  logic        wb_valid;
  logic [1:0]  wb_id;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic [7:0]  busy;
`ifdef FPM_PERF_CNT_EN
  logic [15:0] issue_cnt, stall_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Stand-in multiplier: truncating FP16 multiply for normal operands/zero.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] p;
    logic [6:0]  e;
    s = a[15] ^ b[15];
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = {2'b0, a[14:10]} + {2'b0, b[14:10]} - 7'd15;
    if (p[21]) return {s, e[4:0] + 5'd1, p[20:11]};
    return {s, e[4:0], p[19:10]};
  endfunction

  assign mul_out = fmul(mul_a, mul_b);

  fpm_issue_ctrl #(.NREQ(4), .NREG(8), .LAT(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mul_out),
    .wb_valid(wb_valid), .wb_id(wb_id), .wb_dst(wb_dst), .wb_data(wb_data),
    .busy(busy)
`ifdef FPM_PERF_CNT_EN
    , .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] d);
    req_valid[i]       = v;
    req_a[i*16 +: 16]  = a;
    req_b[i*16 +: 16]  = b;
    req_dst[i*3 +: 3]  = d;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at 1ns after the edge that starts cycle 0, rst low.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_dst   = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic [3:0]  t2_rdy  [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2, 4'h4};
  logic [15:0] t2_data [4] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500};

  initial begin
    // Reset values, with requests pending during reset
    rst = 1'b1;
    req_valid = 4'hF;
    req_a = {4{16'h3C00}};
    req_b = {4{16'h4000}};
    req_dst = {3'd3, 3'd2, 3'd1, 3'd0};
    #7;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wbv",   32'(wb_valid),  32'h0);
    chk("rst_wbid",  32'(wb_id),     32'h0);
    chk("rst_wbdst", 32'(wb_dst),    32'h0);
    chk("rst_wbdat", 32'(wb_data),   32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_mula",  32'(mul_a),     32'h0);
    chk("rst_mulb",  32'(mul_b),     32'h0);

    // Single issue: 1.5 * 2.0 -> 3.0 into r2
    do_reset();
    set_req(0, 1'b1, 16'h3E00, 16'h4000, 3'd2);
    #3;
    chk("t1_c0_ready", 32'(req_ready), 32'h1);
    chk("t1_c0_mula",  32'(mul_a),     32'h3E00);
    chk("t1_c0_mulb",  32'(mul_b),     32'h4000);
    chk("t1_c0_busy",  32'(busy),      32'h00);
    cyc(); req_valid[0] = 1'b0; #3;
    chk("t1_c1_busy",  32'(busy),      32'h04);
    chk("t1_c1_mula",  32'(mul_a),     32'h0);
    cyc(); #3;
    chk("t1_c2_wbv",   32'(wb_valid),  32'h0);
    cyc(); #3;
    chk("t1_c3_wbv",   32'(wb_valid),  32'h1);
    chk("t1_c3_wbid",  32'(wb_id),     32'h0);
    chk("t1_c3_wbdst", 32'(wb_dst),    32'h2);
    chk("t1_c3_wbdat", 32'(wb_data),   32'h4200);
    chk("t1_c3_busy",  32'(busy),      32'h04);
    cyc(); #3;
    chk("t1_c4_busy",  32'(busy),      32'h00);
    chk("t1_c4_wbv",   32'(wb_valid),  32'h0);

    // Round-robin: all four requesters continuously valid, dst 0..3
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'h3C00, t2_data[i], 3'(i));
    for (int c = 0; c < 7; c++) begin
      if (c > 0) cyc();
      #3;
      chk($sformatf("t2_c%0d_ready", c), 32'(req_ready), 32'(t2_rdy[c]));
      if (c < 3) begin
        chk($sformatf("t2_c%0d_wbv", c), 32'(wb_valid), 32'h0);
      end else begin
        chk($sformatf("t2_c%0d_wbv", c),   32'(wb_valid), 32'h1);
        chk($sformatf("t2_c%0d_wbid", c),  32'(wb_id),    32'(c - 3));
        chk($sformatf("t2_c%0d_wbdst", c), 32'(wb_dst),   32'(c - 3));
        chk($sformatf("t2_c%0d_wbdat", c), 32'(wb_data),  32'(t2_data[c-3]));
      end
    end

    // WAW hazard on r5
    do_reset();
    set_req(1, 1'b1, 16'h3C00, 16'h4400, 3'd5);
    #3;
    chk("t3_c0_ready", 32'(req_ready), 32'h2);
    cyc();
    req_valid[1] = 1'b0;
    set_req(2, 1'b1, 16'h3C00, 16'h4500, 3'd5);
    #3;
    chk("t3_c1_ready", 32'(req_ready), 32'h0);
    chk("t3_c1_busy",  32'(busy),      32'h20);
    cyc(); #3;
    chk("t3_c2_ready", 32'(req_ready), 32'h0);
    cyc(); #3;
    chk("t3_c3_ready", 32'(req_ready), 32'h0);
    chk("t3_c3_wbv",   32'(wb_valid),  32'h1);
    chk("t3_c3_wbid",  32'(wb_id),     32'h1);
    chk("t3_c3_wbdat", 32'(wb_data),   32'h4400);
    cyc(); #3;
    chk("t3_c4_ready", 32'(req_ready), 32'h4);
    chk("t3_c4_busy",  32'(busy),      32'h00);
    cyc(); req_valid[2] = 1'b0; #3;
    chk("t3_c5_busy",  32'(busy),      32'h20);
`ifdef FPM_PERF_CNT_EN
    chk("t3_issue_cnt", 32'(issue_cnt), 32'd2);
    chk("t3_stall_cnt", 32'(stall_cnt), 32'd3);
`endif
    cyc(); #3;
    chk("t3_c6_wbv",   32'(wb_valid),  32'h0);
    cyc(); #3;
    chk("t3_c7_wbv",   32'(wb_valid),  32'h1);
    chk("t3_c7_wbid",  32'(wb_id),     32'h2);
    chk("t3_c7_wbdst", 32'(wb_dst),    32'h5);
    chk("t3_c7_wbdat", 32'(wb_data),   32'h4500);

    // Same-destination collision between req0 and req3
    do_reset();
    set_req(0, 1'b1, 16'h3C00, 16'h4000, 3'd1);
    set_req(3, 1'b1, 16'h3C00, 16'h4200, 3'd1);
    #3;
    chk("t4_c0_ready", 32'(req_ready), 32'h1);
    cyc(); req_valid[0] = 1'b0; #3;
    chk("t4_c1_ready", 32'(req_ready), 32'h0);
    cyc(); #3;
    chk("t4_c2_ready", 32'(req_ready), 32'h0);
    cyc(); #3;
    chk("t4_c3_ready", 32'(req_ready), 32'h0);
    cyc(); #3;
    chk("t4_c4_ready", 32'(req_ready), 32'h8);
    chk("t4_c4_mulb",  32'(mul_b),     32'h4200);

    // Reset mid-flight
    do_reset();
    set_req(0, 1'b1, 16'h3C00, 16'h4000, 3'd0);
    #3;
    chk("t5_c0_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid[0] = 1'b0;
    set_req(1, 1'b1, 16'h3C00, 16'h4200, 3'd1);
    #3;
    chk("t5_c1_ready", 32'(req_ready), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ready", 32'(req_ready), 32'h0);
    chk("t5_rst_busy",  32'(busy),      32'h0);
    chk("t5_rst_wbv",   32'(wb_valid),  32'h0);
    chk("t5_rst_mula",  32'(mul_a),     32'h0);
    cyc();
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) cyc();
      #3;
      chk($sformatf("t5_post%0d_wbv", c),  32'(wb_valid), 32'h0);
      chk($sformatf("t5_post%0d_busy", c), 32'(busy),     32'h0);
    end
    cyc();
    set_req(0, 1'b1, 16'h3C00, 16'h4000, 3'd0);
    set_req(1, 1'b1, 16'h3C00, 16'h4200, 3'd1);
    #3;
    chk("t5_first_grant", 32'(req_ready), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpm_issue_ctrl.md
Name: fpm_issue_ctrl

Overview:
- Issue controller and scoreboard that shares one combinational FP16 multiplier (fpm) among NREQ requesters.
- Each cycle it picks one eligible request by round-robin and drives the multiplier operands.
- It carries the result through a LAT-stage writeback pipeline and returns it tagged with requester id and destination register.
- A per-register busy table blocks WAW hazards until the result is written back.

Parameters:
NREQ, 4, number of requesters (2..8)
NREG, 8, number of destination registers tracked by the scoreboard
LAT, 3, cycles from issue to wb_valid (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NREQ  per-requester request valid
req_a  input  16*NREQ  operand A, IEEE-754 half; requester i at [16i+15:16i]
req_b  input  16*NREQ  operand B, same packing
req_dst  input  $clog2(NREG)*NREQ  destination register per requester
req_ready  output  NREQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
mul_a  output  16  operand A to fpm
mul_b  output  16  operand B to fpm
mul_out  input  16  fpm product (combinational from mul_a/mul_b)
wb_valid  output  1  writeback valid, one cycle per result
wb_id  output  $clog2(NREQ)  requester that issued the result
wb_dst  output  $clog2(NREG)  destination register
wb_data  output  16  FP16 product
busy  output  NREG  scoreboard busy bits

Behaviour:
- Reset (async, rst=1):
  - req_ready=0, wb_valid=0, wb_id=0, wb_dst=0, wb_data=0, busy=0, mul_a=mul_b=0.
  - All pipeline stages invalid; RR pointer = NREQ-1, so requester 0 has first priority.
  - Reset mid-operation drops in-flight results silently; no wb_valid for them.
- Eligibility:
  - Requester i is eligible when req_valid[i]=1 and busy[req_dst_i]=0, using the registered busy value.
- Grant:
  - Combinational. Search starts at ptr+1 mod NREQ; the first eligible requester gets req_ready[i]=1. At most one bit is set.
  - On grant, ptr <= i. With no grant, ptr holds.
- Issue (cycle t):
  - mul_a/mul_b = granted operands (zero when idle).
  - Stage-1 register captures {valid=1, id, dst, mul_out} at the edge ending cycle t.
  - busy[dst] <= 1.
- Pipeline:
  - LAT stages, shifting every cycle with no backpressure.
  - Stage LAT drives wb_*. wb_valid is high in cycle t+LAT.
  - Issue rate is 1 per cycle; throughput is 1 result per cycle.
- Busy clear:
  - In the cycle wb_valid=1, busy[wb_dst] <= 0 at the next edge.
  - A request to that dst presented during the wb_valid cycle still sees busy=1. It is granted in the following cycle at the earliest.
- Same-cycle set and clear on different registers are independent. The same register cannot be set and cleared in the same cycle, because eligibility prevents it.
- Two requesters targeting the same free dst in one cycle: only the RR winner issues. The loser sees busy next cycle and stalls until writeback.
- Requests hold stable while valid and not ready. Dropping valid before grant is permitted (no issue).
- wb_data passes mul_out through unmodified. Special values (zero, inf) are the fpm's responsibility.

Optional Feature:
- Macro FPM_PERF_CNT_EN.
- Defined:
  - Adds outputs issue_cnt[15:0] and stall_cnt[15:0].
  - issue_cnt increments on every grant.
  - stall_cnt increments each cycle in which some req_valid is high with no grant (all blocked by busy).
  - Both saturate at 0xFFFF and reset to 0.
- Undefined: the ports and logic are absent. Functional behaviour is otherwise identical.

Test Plan:
- Single issue: req0 a=0x3E00 (1.5), b=0x4000 (2.0), dst=2 at cycle 0 (LAT=3) -> req_ready=0001 in cycle 0; busy[2]=1 from cycle 1; wb_valid=1 at cycle 3 with id=0, dst=2, data=0x4200; busy[2]=0 at cycle 4.
- Round-robin: all 4 requesters valid with dst 0..3 continuously from reset -> grants 0,1,2,3 in cycles 0-3; results at cycles 3-6 in the same order, one per cycle.
- WAW hazard: req1 dst=5 issues at cycle 0; req2 dst=5 valid from cycle 1 -> req2 not granted until cycle 4 (wb at 3, busy clears edge 4); req2 wb at cycle 7.
- Same-dst collision: req0 and req3 both dst=1 in cycle 0 after reset -> req0 granted, req3 stalls until cycle 4.
- Reset mid-flight: issue 2 ops, assert rst in cycle 1 -> all outputs 0 immediately; no wb_valid afterwards; busy=0; next grant goes to requester 0.
- FPM_PERF_CNT_EN: in the WAW scenario -> issue_cnt=2; stall_cnt=3 (cycles 1-3).
